i_o_input_queue: RTL and testbench
==================================

I_O_INPUT_QUEUE -- requirements
Module: i_o_input_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 16: byte capacity; power of two, 2..256.
REQ-002 SHALL have parameter CW, default $clog2(DEPTH+1): width of the level output.
REQ-003 SHALL have port clk, input, 1: the single clock; all logic samples on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-005 SHALL have port io_input_trigger, input, 1: one-cycle pulse from the UART receiver meaning a received byte is valid.
REQ-006 SHALL have port io_input_value, input, 8: the received byte, valid when io_input_trigger is high.
REQ-007 SHALL have port enable, input, 1: when low, the queue ignores incoming bytes.
REQ-008 SHALL have port flush, input, 1: one-cycle request to discard all stored bytes.
REQ-009 SHALL have port rd_valid, output, 1: the head byte is available.
REQ-010 SHALL have port rd_value, output, 8: the head byte.
REQ-011 SHALL have port rd_ready, input, 1: the consumer accepts the head byte.
REQ-012 SHALL have port level, output, CW: number of stored bytes.
REQ-013 SHALL have port overflow, output, 1: sticky flag meaning a byte was lost because the queue was full.
REQ-014 SHALL have port clear_overflow, input, 1: one-cycle request to clear the overflow flag.
REQ-015 SHALL have port drop_count, output, 16: count of lost bytes (see REQ-034).

Function
REQ-016 SHALL define push as io_input_trigger && enable && !flush.
REQ-017 SHALL define pop as rd_valid && rd_ready && !flush.
REQ-018 SHALL store a pushed byte in circular storage at the write pointer, then advance the pointer modulo DEPTH.
REQ-019 SHALL advance the read pointer modulo DEPTH on pop; pointers wrap from DEPTH-1 to 0 without loss.
REQ-020 SHALL have no fall-through: a byte pushed into an empty queue at edge N asserts rd_valid and presents the byte from edge N onward (visible the cycle after the trigger).
REQ-021 SHALL hold rd_valid = (level != 0), and SHALL hold rd_value stable while rd_valid is high and no pop occurs.
REQ-022 SHALL update level by +1 on push only, -1 on pop only, and leave it unchanged on simultaneous push and pop.
REQ-023 SHALL, when full with push and pop in the same cycle, accept the push and set neither overflow nor drop_count.
REQ-024 SHALL, when full with push and no pop, discard the incoming byte, leave the contents unchanged and set overflow on the next edge.
REQ-025 SHALL treat pop while empty as a no-op: no pointer movement and no underflow.
REQ-026 SHALL, on flush, zero both pointers and level on the next edge and drop any same-cycle push or pop; overflow is unchanged.
REQ-027 SHALL, on clear_overflow, clear overflow on the next edge; if an overflow event occurs in the same cycle, set wins.
REQ-028 SHALL drop triggers while enable is low, without setting overflow or counting them; stored bytes remain readable.
REQ-029 SHALL present all outputs registered or derived only from registers, with no combinational path from inputs to outputs.

Reset
REQ-030 SHALL, when rst_n is low at a clock edge, force pointers to 0, level to 0, rd_valid to 0, overflow to 0 and drop_count to 0.
REQ-031 SHALL, on reset mid-operation, discard any partial or in-flight byte; storage contents need not be cleared.
REQ-032 SHALL give reset priority over flush, push, pop and clear_overflow.

Configuration
REQ-033 SHALL use the macro I_O_INPUT_QUEUE_STATS_EN to select the drop counter.
REQ-034 SHALL, when the macro is defined, increment drop_count on each overflow event (REQ-024), saturate it at 16'hFFFF and clear it together with overflow on clear_overflow; set wins over clear.
REQ-035 SHALL, when the macro is undefined, tie drop_count to 0 and include no counter logic; all other behaviour is identical.

Verification
REQ-036 SHALL cover: push 0x55 on empty queue, rd_ready=0 -> rd_valid=1 and rd_value=0x55 the next cycle, level=1.
REQ-037 SHALL cover: with DEPTH=16, push 17 bytes 0x00..0x10, no pop -> level=16, overflow=1, drop_count=1 (STATS_EN), head=0x00, 0x10 lost.
REQ-038 SHALL cover: full queue, push 0xAA and pop in the same cycle -> level stays 16, overflow=0, 0xAA is read 16th.
REQ-039 SHALL cover: 40 bytes streamed with rd_ready=1 continuously -> all 40 read in order, pointers wrap twice, level never exceeds 1.
REQ-040 SHALL cover: level=5, flush and push in the same cycle -> level=0 and rd_valid=0 next cycle; then rst_n low for one edge mid-stream -> all outputs at reset values.
REQ-041 SHALL cover: enable=0 with 3 triggers -> level unchanged, overflow=0, drop_count=0.

Source files
------------

// File: rtl/i_o_input_queue.sv
// Byte queue between the UART receiver and its consumer; circular storage of DEPTH bytes.
// Latency: a byte pushed at edge N is visible on rd_valid/rd_value from edge N onward (no fall-through).
// Backpressure: consumer stalls with rd_ready=0; when full, a new byte is dropped unless a pop frees the slot that cycle.
//
// Optional feature: define I_O_INPUT_QUEUE_STATS_EN to build the saturating 16-bit drop counter;
// otherwise drop_count is tied to zero.
//
// Ports:
//   clk, rst_n                       - clock, synchronous active-low reset
//   io_input_trigger, io_input_value - one-cycle byte strobe and byte from the receiver
//   enable                           - when low, incoming bytes are ignored (not counted as drops)
//   flush                            - discard all stored bytes (pointers and level to zero)
//   rd_valid, rd_value, rd_ready     - head byte handshake toward the consumer
//   level                            - number of stored bytes
//   overflow, clear_overflow         - sticky lost-byte flag and its clear request
//   drop_count                       - number of lost bytes (zero unless stats are built in)
module i_o_input_queue #(
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          io_input_trigger,
  input  logic [7:0]    io_input_value,
  input  logic          enable,
  input  logic          flush,
  output logic          rd_valid,
  output logic [7:0]    rd_value,
  input  logic          rd_ready,
  output logic [CW-1:0] level,
  output logic          overflow,
  input  logic          clear_overflow,
  output logic [15:0]   drop_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] level_q;
  logic          overflow_q;

  logic push;
  logic pop;
  logic full;
  logic push_acc;
  logic ovf_evt;

  assign full     = (level_q == CW'(DEPTH));
  assign push     = io_input_trigger && enable && !flush;
  assign pop      = (level_q != '0) && rd_ready && !flush;
  // A full queue still accepts a byte when the head leaves in the same cycle:
  // the write lands in the slot the read pointer is vacating.
  assign push_acc = push && (!full || pop);
  assign ovf_evt  = push && full && !pop;

  // Storage is not reset; validity is tracked entirely by level/pointers.
  always_ff @(posedge clk) begin
    if (rst_n && push_acc) begin
      mem[wr_ptr] <= io_input_value;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      // DEPTH is a power of two, so natural pointer overflow is the modulo wrap.
      if (push_acc) wr_ptr <= wr_ptr + AW'(1);
      if (pop)      rd_ptr <= rd_ptr + AW'(1);
      case ({push_acc, pop})
        2'b10:   level_q <= level_q + CW'(1);
        2'b01:   level_q <= level_q - CW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Set beats clear when both happen in one cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
    end else if (ovf_evt) begin
      overflow_q <= 1'b1;
    end else if (clear_overflow) begin
      overflow_q <= 1'b0;
    end
  end

`ifdef I_O_INPUT_QUEUE_STATS_EN
  logic [15:0] drop_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drop_q <= '0;
    end else if (ovf_evt) begin
      if (drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
    end else if (clear_overflow) begin
      drop_q <= '0;
    end
  end

  assign drop_count = drop_q;
`else
  assign drop_count = 16'd0;
`endif

  assign rd_valid = (level_q != '0);
  assign rd_value = mem[rd_ptr];
  assign level    = level_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_i_o_input_queue.sv
module tb_i_o_input_queue;

  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          io_input_trigger;
  logic [7:0]    io_input_value;
  logic          enable;
  logic          flush;
  logic          rd_valid;
  logic [7:0]    rd_value;
  logic          rd_ready;
  logic [CW-1:0] level;
  logic          overflow;
  logic          clear_overflow;
  logic [15:0]   drop_count;

  int checks   = 0;
  int failures = 0;

  // Reference model: the queue as a list of bytes, plus flag and drop tally.
  logic [7:0] q[$];
  logic       m_ovf;
  int         m_drops;
  int         max_level;

  i_o_input_queue #(.DEPTH(DEPTH)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .io_input_trigger (io_input_trigger),
    .io_input_value   (io_input_value),
    .enable           (enable),
    .flush            (flush),
    .rd_valid         (rd_valid),
    .rd_value         (rd_value),
    .rd_ready         (rd_ready),
    .level            (level),
    .overflow         (overflow),
    .clear_overflow   (clear_overflow),
    .drop_count       (drop_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic t, input logic [7:0] v, input logic en,
                        input logic fl, input logic rdy, input logic clr);
    io_input_trigger = t;
    io_input_value   = v;
    enable           = en;
    flush            = fl;
    rd_ready         = rdy;
    clear_overflow   = clr;
  endtask

  // Advance one clock: update the model from the current inputs, then compare.
  task automatic tick();
    bit do_push, do_pop, was_full, evt;
    evt = 0;
    if (!rst_n) begin
      q.delete();
      m_ovf   = 0;
      m_drops = 0;
    end else begin
      do_push  = io_input_trigger && enable && !flush;
      do_pop   = (q.size() != 0) && rd_ready && !flush;
      was_full = (q.size() == DEPTH);
      if (flush) q.delete();
      else begin
        if (do_pop) void'(q.pop_front());
        if (do_push) begin
          if (was_full && !do_pop) evt = 1;
          else q.push_back(io_input_value);
        end
      end
      if (evt) begin
        m_ovf = 1;
        if (m_drops < 16'hFFFF) m_drops++;
      end else if (clear_overflow) begin
        m_ovf   = 0;
        m_drops = 0;
      end
    end
    @(posedge clk);
    #1;
    if (q.size() > max_level) max_level = q.size();
    chk("rd_valid", 32'(rd_valid), 32'(q.size() != 0));
    chk("level", 32'(level), 32'(q.size()));
    chk("overflow", 32'(overflow), 32'(m_ovf));
`ifdef I_O_INPUT_QUEUE_STATS_EN
    chk("drop_count", 32'(drop_count), 32'(m_drops));
`else
    chk("drop_count", 32'(drop_count), 32'd0);
`endif
    if (q.size() != 0) chk("rd_value", 32'(rd_value), 32'(q[0]));
  endtask

  initial begin
    m_ovf = 0; m_drops = 0; max_level = 0;
    rst_n = 1'b0;
    set_in(0, 8'h00, 1, 0, 0, 0);
    tick();
    tick();
    rst_n = 1'b1;

    // Single push into empty queue, consumer stalled.
    set_in(1, 8'h55, 1, 0, 0, 0); tick();
    chk("push55_value", 32'(rd_value), 32'h55);
    chk("push55_level", 32'(level), 32'd1);
    set_in(0, 8'h00, 1, 0, 1, 0); tick();

    // Fill past capacity: 17 bytes 0x00..0x10, the last is lost.
    for (int i = 0; i <= 16; i++) begin
      set_in(1, 8'(i), 1, 0, 0, 0); tick();
    end
    chk("fill_level", 32'(level), 32'd16);
    chk("fill_ovf", 32'(overflow), 32'd1);
    chk("fill_head", 32'(rd_value), 32'h00);

    // Clear the flag, then push 0xAA while popping on a full queue.
    set_in(0, 8'h00, 1, 0, 0, 1); tick();
    set_in(1, 8'hAA, 1, 0, 1, 0); tick();
    chk("fullpp_level", 32'(level), 32'd16);
    chk("fullpp_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < 15; i++) begin
      set_in(0, 8'h00, 1, 0, 1, 0); tick();
    end
    chk("aa_is_16th", 32'(rd_value), 32'hAA);
    set_in(0, 8'h00, 1, 0, 1, 0); tick();
    tick();  // pop while empty is a no-op
    chk("empty_level", 32'(level), 32'd0);

    // Stream 40 bytes with the consumer always ready.
    max_level = 0;
    for (int i = 0; i < 40; i++) begin
      set_in(1, 8'(8'h80 + i), 1, 0, 1, 0); tick();
    end
    set_in(0, 8'h00, 1, 0, 1, 0); tick();
    chk("stream_maxlvl", 32'(max_level), 32'd1);

    // Build level 5, then flush with a simultaneous push.
    for (int i = 0; i < 5; i++) begin
      set_in(1, 8'(8'h30 + i), 1, 0, 0, 0); tick();
    end
    chk("lvl5", 32'(level), 32'd5);
    set_in(1, 8'hEE, 1, 1, 0, 0); tick();
    chk("flush_level", 32'(level), 32'd0);
    chk("flush_valid", 32'(rd_valid), 32'd0);

    // Reset for one edge mid-stream.
    for (int i = 0; i < 3; i++) begin
      set_in(1, 8'(8'h40 + i), 1, 0, 0, 0); tick();
    end
    rst_n = 1'b0;
    set_in(1, 8'h99, 1, 0, 1, 0); tick();
    rst_n = 1'b1;
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_valid", 32'(rd_valid), 32'd0);

    // Enable low: triggers are ignored, stored bytes stay readable.
    set_in(1, 8'h11, 1, 0, 0, 0); tick();
    for (int i = 0; i < 3; i++) begin
      set_in(1, 8'(8'h20 + i), 0, 0, 0, 0); tick();
    end
    chk("dis_level", 32'(level), 32'd1);
    chk("dis_ovf", 32'(overflow), 32'd0);
    chk("dis_head", 32'(rd_value), 32'h11);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      set_in(($urandom_range(0, 99) < 60), 8'($urandom),
             ($urandom_range(0, 99) < 90), ($urandom_range(0, 99) < 3),
             ($urandom_range(0, 99) < 40), ($urandom_range(0, 99) < 5));
      rst_n = ($urandom_range(0, 199) != 0);
      tick();
      rst_n = 1'b1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
